// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a show-ahead receive FIFO
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rdreq,
  input  logic       err_clr,
  output logic [7:0] q,
  output logic       empty,
  output logic       full,
  output logic       ovf,
  output logic       ferr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]      BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]      HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rxd_meta, rxd_s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, idx_nx;
  logic [7:0]       shreg, sh_nx;
  // Set once a low stop bit is seen; holds STOP until the line returns high.
  logic             brk_wait, brk_nx;
  logic             push, ferr_set;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nx;
  logic                  pop, wr_en, ovf_set;

  // Synchronizer and receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      brk_wait <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= idx_nx;
      shreg    <= sh_nx;
      brk_wait <= brk_nx;
    end
  end

  // Receiver next-state: bit timing, sampling, push and framing-error strobes.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    idx_nx   = bit_idx;
    sh_nx    = shreg;
    brk_nx   = brk_wait;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        idx_nx = '0;
        brk_nx = 1'b0;
        if (!rxd_s) state_nx = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_nx   = '0;
          state_nx = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nx = '0;
          sh_nx  = {rxd_s, shreg[7:1]};
          idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (brk_wait) begin
          cnt_nx = '0;
          if (rxd_s) state_nx = IDLE;
        end else if (cnt == BIT_END) begin
          cnt_nx = '0;
          if (rxd_s) begin
            push     = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_set = 1'b1;
            brk_nx   = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pop      = rdreq && !empty;
  assign wr_en    = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign q        = mem[rd_ptr];

  // Occupancy update from the accepted push/pop pair.
  always_comb begin
    count_nx = count;
    if (wr_en && !pop)      count_nx = count + (DEPTH_LOG2 + 1)'(1);
    else if (!wr_en && pop) count_nx = count - (DEPTH_LOG2 + 1)'(1);
  end

  // FIFO storage; contents need no reset since q is don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, count, registered status and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count_nx;
      empty <= (count_nx == '0);
      full  <= (count_nx == FULL_CNT);
      if (ovf_set)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (ferr_set)     ferr <= 1'b1;
      else if (err_clr) ferr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo at 16 clocks per bit
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rdreq = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] q;
  logic       empty, full, ovf, ferr;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb[$];
  logic       exp_ovf = 1'b0;
  logic       exp_ferr = 1'b0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rdreq(rdreq), .err_clr(err_clr),
    .q(q), .empty(empty), .full(full), .ovf(ovf), .ferr(ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rdreq) begin
      if (!empty) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual=%0h required=empty", q);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          check("pop_data", {24'd0, q}, {24'd0, e});
        end
      end else if (sb.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL missing_pop actual=empty required=%0h", sb[0]);
      end
    end
  end

  task automatic check_flags(input string tag);
    @(negedge clk);
    check({tag, "_empty"}, {31'd0, empty}, {31'd0, sb.size() == 0});
    check({tag, "_full"},  {31'd0, full},  {31'd0, sb.size() == DEPTH});
    check({tag, "_ovf"},   {31'd0, ovf},   {31'd0, exp_ovf});
    check({tag, "_ferr"},  {31'd0, ferr},  {31'd0, exp_ferr});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    rxd = 1'b1;
    rdreq = 1'b0;
    err_clr = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    #3;
    check_flags("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; optional rdreq / err_clr pulse aligned to the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic rd_at_stop, input logic clr_at_stop);
    @(posedge clk); #1;
    fork
      begin
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          rxd = b[i];
          repeat (CPB) @(posedge clk);
          #1;
        end
        rxd = stop_bit;
        repeat (CPB) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
      end
      begin
        if (rd_at_stop || clr_at_stop) begin
          repeat (154) @(posedge clk);
          #1;
          rdreq = rd_at_stop;
          err_clr = clr_at_stop;
          @(posedge clk);
          #1;
          rdreq = 1'b0;
          err_clr = 1'b0;
        end
      end
    join
    if (clr_at_stop) begin
      exp_ovf = 1'b0;
      exp_ferr = 1'b0;
    end
    if (stop_bit) begin
      if (sb.size() < DEPTH) sb.push_back(b);
      else exp_ovf = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic read_n(input int n);
    if (n > 0) begin
      @(posedge clk); #1 rdreq = 1'b1;
      repeat (n) @(posedge clk);
      #1 rdreq = 1'b0;
    end
  endtask

  task automatic clear_errs();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    do_reset();

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_flags("single");
    check("single_q", {24'd0, q}, 32'hA5);
    read_n(1);
    check_flags("single_drained");

    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      if (i >= 15) check_flags("fill");
    end
    read_n(16);
    check_flags("overflow_drained");
    clear_errs();

    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
    check_flags("refill");
    send_frame(8'hE7, 1'b1, 1'b1, 1'b0);
    check_flags("push_pop_full");
    read_n(DEPTH);
    check_flags("push_pop_drained");

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_flags("ferr");
    clear_errs();
    check_flags("ferr_cleared");
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    check_flags("ferr_beats_clr");
    clear_errs();

    @(posedge clk); #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check_flags("glitch");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    check_flags("after_glitch");
    read_n(1);

    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 rxd = 1'(8'h77 >> i);
      repeat (CPB) @(posedge clk);
    end
    #1 rst_n = 1'b0;
    rxd = 1'b1;
    sb.delete();
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check_flags("post_reset");
    check("post_reset_q", {24'd0, q}, 32'h5A);
    read_n(1);
    check_flags("post_reset_drained");

    for (int it = 0; it < 40; it++) begin
      logic [7:0] b;
      logic       stop;
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop, 1'b0, 1'b0);
      read_n($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) clear_errs();
      check_flags("random");
    end
    read_n(DEPTH + 2);
    check_flags("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
